// File: rtl/disp_share_arb.sv
// Shares one 2-digit binary path to a 7-segment decoder between two requesters.
// Values are saturated to 0..99 and the shown channel rotates after a dwell time.
module disp_share_arb #(
  parameter int DWELL = 50_000_000,
  parameter int CW    = $clog2(DWELL)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       upd_a,
  input  logic [6:0] val_a,
  input  logic       clr_a,
  input  logic       upd_b,
  input  logic [6:0] val_b,
  input  logic       clr_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [6:0] bin_out,
  output logic       sel,
  output logic       blank,
  output logic       ovf_a,
  output logic       ovf_b
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHOW_A = 2'd1,
    SHOW_B = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DWELL - 1);

  function automatic logic [6:0] sat99(input logic [6:0] v);
    return (v > 7'd99) ? 7'd99 : v;
  endfunction

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [6:0]    reg_a_r, reg_b_r;
  logic          has_a_r, has_b_r;
  logic          has_a_nxt_s, has_b_nxt_s;
  logic          ovf_a_r, ovf_b_r;
  logic          ack_a_r, ack_b_r;
  logic          acc_a_s, acc_b_s;

  // Clear beats update; next-state decisions see post-edge has_data values.
  always_comb begin
    acc_a_s = upd_a & ~clr_a;
    acc_b_s = upd_b & ~clr_b;
    if (clr_a) begin
      has_a_nxt_s = 1'b0;
    end else if (upd_a) begin
      has_a_nxt_s = 1'b1;
    end else begin
      has_a_nxt_s = has_a_r;
    end
    if (clr_b) begin
      has_b_nxt_s = 1'b0;
    end else if (upd_b) begin
      has_b_nxt_s = 1'b1;
    end else begin
      has_b_nxt_s = has_b_r;
    end
  end

  // Next-state and dwell counter selection.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = {CW{1'b0}};
    case (state_r)
      IDLE: begin
        if (has_a_nxt_s) begin
          state_nxt_s = SHOW_A;
        end else if (has_b_nxt_s) begin
          state_nxt_s = SHOW_B;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SHOW_A: begin
        if (!has_a_nxt_s) begin
          state_nxt_s = has_b_nxt_s ? SHOW_B : IDLE;
        end else if ((cnt_r == CNT_MAX) && has_b_nxt_s) begin
          state_nxt_s = SHOW_B;
        end else begin
          state_nxt_s = SHOW_A;
        end
      end
      SHOW_B: begin
        if (!has_b_nxt_s) begin
          state_nxt_s = has_a_nxt_s ? SHOW_A : IDLE;
        end else if ((cnt_r == CNT_MAX) && has_a_nxt_s) begin
          state_nxt_s = SHOW_A;
        end else begin
          state_nxt_s = SHOW_B;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
    // Counter restarts on any state change, wraps while a channel stays shown.
    if ((state_nxt_s != state_r) || (state_nxt_s == IDLE)) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (cnt_r == CNT_MAX) begin
      cnt_nxt_s = {CW{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
    end
  end

  // State register and dwell counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Channel value, data-valid, overflow and acknowledge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_r <= 7'd0;
      reg_b_r <= 7'd0;
      has_a_r <= 1'b0;
      has_b_r <= 1'b0;
      ovf_a_r <= 1'b0;
      ovf_b_r <= 1'b0;
      ack_a_r <= 1'b0;
      ack_b_r <= 1'b0;
    end else begin
      has_a_r <= has_a_nxt_s;
      has_b_r <= has_b_nxt_s;
      ack_a_r <= acc_a_s;
      ack_b_r <= acc_b_s;
      if (acc_a_s) begin
        reg_a_r <= sat99(val_a);
        ovf_a_r <= (val_a > 7'd99);
      end else if (clr_a) begin
        ovf_a_r <= 1'b0;
      end else begin
        ovf_a_r <= ovf_a_r;
      end
      if (acc_b_s) begin
        reg_b_r <= sat99(val_b);
        ovf_b_r <= (val_b > 7'd99);
      end else if (clr_b) begin
        ovf_b_r <= 1'b0;
      end else begin
        ovf_b_r <= ovf_b_r;
      end
    end
  end

  // Output decode from registered state.
  always_comb begin
    bin_out = 7'd0;
    sel     = 1'b0;
    blank   = 1'b0;
    case (state_r)
      IDLE: begin
        blank = 1'b1;
      end
      SHOW_A: begin
        bin_out = reg_a_r;
      end
      SHOW_B: begin
        bin_out = reg_b_r;
        sel     = 1'b1;
      end
      default: begin
        blank = 1'b1;
      end
    endcase
  end

  assign ack_a = ack_a_r;
  assign ack_b = ack_b_r;
  assign ovf_a = ovf_a_r;
  assign ovf_b = ovf_b_r;

endmodule

// File: tb/tb_disp_share_arb.sv
// Randomized and directed bench for disp_share_arb against a behavioural
// model of two display channels rotating with an 8-cycle dwell.
module tb_disp_share_arb;

  localparam int DWELL = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       upd_a, clr_a, upd_b, clr_b;
  logic [6:0] val_a, val_b;
  logic       ack_a, ack_b, sel, blank, ovf_a, ovf_b;
  logic [6:0] bin_out;

  int n_cmp = 0;
  int n_bad = 0;

  // model: per-channel value/valid/overflow, shown channel (-1 blank), cycles shown
  int m_val[2];
  int m_has[2];
  int m_ovf[2];
  int m_ack[2];
  int m_shown;
  int m_dwell;

  disp_share_arb #(.DWELL(DWELL)) dut (
    .clk(clk), .rst_n(rst_n),
    .upd_a(upd_a), .val_a(val_a), .clr_a(clr_a),
    .upd_b(upd_b), .val_b(val_b), .clr_b(clr_b),
    .ack_a(ack_a), .ack_b(ack_b), .bin_out(bin_out),
    .sel(sel), .blank(blank), .ovf_a(ovf_a), .ovf_b(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_val[i] = 0; m_has[i] = 0; m_ovf[i] = 0; m_ack[i] = 0;
    end
    m_shown = -1;
    m_dwell = 0;
  endtask

  task automatic model_step(input int u[2], input int v[2], input int c[2]);
    int prev;
    for (int i = 0; i < 2; i++) begin
      m_ack[i] = (u[i] != 0 && c[i] == 0) ? 1 : 0;
      if (c[i] != 0) begin
        m_has[i] = 0; m_ovf[i] = 0;
      end else if (u[i] != 0) begin
        m_val[i] = (v[i] > 99) ? 99 : v[i];
        m_ovf[i] = (v[i] > 99) ? 1 : 0;
        m_has[i] = 1;
      end
    end
    prev = m_shown;
    if (m_shown < 0) begin
      m_shown = m_has[0] ? 0 : (m_has[1] ? 1 : -1);
    end else if (!m_has[m_shown]) begin
      m_shown = m_has[1 - m_shown] ? 1 - m_shown : -1;
    end else if (m_dwell == DWELL - 1 && m_has[1 - m_shown]) begin
      m_shown = 1 - m_shown;
    end
    if (m_shown != prev || m_shown < 0) m_dwell = 0;
    else m_dwell = (m_dwell + 1) % DWELL;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".ack_a"}, ack_a, m_ack[0]);
    chk({tag, ".ack_b"}, ack_b, m_ack[1]);
    chk({tag, ".ovf_a"}, ovf_a, m_ovf[0]);
    chk({tag, ".ovf_b"}, ovf_b, m_ovf[1]);
    chk({tag, ".bin"}, bin_out, (m_shown < 0) ? 0 : m_val[m_shown]);
    chk({tag, ".sel"}, sel, (m_shown == 1) ? 1 : 0);
    chk({tag, ".blank"}, blank, (m_shown < 0) ? 1 : 0);
  endtask

  // one clock cycle: drive inputs, advance model at the edge, compare after it
  task automatic step(input string tag, input int ua, input int va, input int ca,
                      input int ub, input int vb, input int cb);
    int u[2]; int v[2]; int c[2];
    u[0] = ua; v[0] = va; c[0] = ca;
    u[1] = ub; v[1] = vb; c[1] = cb;
    upd_a = 1'(ua); val_a = 7'(va); clr_a = 1'(ca);
    upd_b = 1'(ub); val_b = 7'(vb); clr_b = 1'(cb);
    @(posedge clk);
    model_step(u, v, c);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  // asynchronous reset away from the clock edge, checked before any edge
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    m_ack[0] = 0; m_ack[1] = 0;
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int guard;
    rst_n = 1'b0;
    upd_a = 1'b0; clr_a = 1'b0; val_a = 7'd0;
    upd_b = 1'b0; clr_b = 1'b0; val_b = 7'd0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    idle("idle", 10);

    // 2: single channel stays shown across several dwell periods
    step("load_a", 1, 42, 0, 0, 0, 0);
    chk("load_a.bin_const", bin_out, 42);
    chk("load_a.ack_const", ack_a, 1);
    idle("hold_a", 3 * DWELL);
    chk("hold_a.sel_const", sel, 0);

    // 3: second channel joins, rotation every DWELL cycles
    step("load_b", 0, 0, 0, 1, 7, 0);
    idle("rotate", 4 * DWELL + 3);

    // 4: saturation and overflow flag
    step("sat_a", 1, 120, 0, 0, 0, 0);
    chk("sat_a.ovf_const", ovf_a, 1);
    step("unsat_a", 1, 5, 0, 0, 0, 0);
    chk("unsat_a.ovf_const", ovf_a, 0);

    // 5: clear shown channel mid-dwell, then clear the other
    guard = 0;
    while (!(m_shown == 0 && m_dwell == 3) && guard < 4 * DWELL) begin
      step("seek_a3", 0, 0, 0, 0, 0, 0);
      guard++;
    end
    chk("seek_a3.reached", (guard < 4 * DWELL) ? 1 : 0, 1);
    step("clr_a_mid", 0, 0, 1, 0, 0, 0);
    chk("clr_a_mid.sel_const", sel, 1);
    idle("after_clr_a", 2);
    step("clr_b", 0, 0, 0, 0, 0, 1);
    chk("clr_b.blank_const", blank, 1);

    // 6: update+clear collision, simultaneous load, reset mid-dwell
    step("upd_clr_a", 1, 33, 1, 0, 0, 0);
    chk("upd_clr_a.ack_const", ack_a, 0);
    idle("upd_clr_idle", 2);
    step("both_load", 1, 11, 0, 1, 22, 0);
    idle("both_run", 5);
    do_reset("rst_mid");
    idle("post_rst", 3);

    // randomized traffic with occasional collisions, clears and resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 127),
             ($urandom_range(0, 19) == 0) ? 1 : 0,
             ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 127),
             ($urandom_range(0, 19) == 0) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
- Shares one 2-digit binary-to-7-segment display path between two requesters, A and B. Example requesters: a player-A score and a player-B score.
- Each requester loads a 7-bit value with an update pulse. The block latches and saturates the value, then drives the shared 7-bit binary input of the display decoder.
- When both channels hold data, the displayed channel alternates round-robin after a programmable dwell time.
- Sits between the game/control logic and the 7-segment decoder.

Parameters:
- DWELL, default 50_000_000: number of clk cycles a channel stays displayed before yielding to the other channel. Minimum 2.
- CW, default $clog2(DWELL): width of the dwell counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- upd_a  in  1  one-cycle pulse: load val_a into channel A.
- val_a  in  7  channel A value, unsigned, 0..127.
- clr_a  in  1  one-cycle pulse: remove channel A from display rotation.
- upd_b  in  1  same as upd_a, for channel B.
- val_b  in  7  same as val_a, for channel B.
- clr_b  in  1  same as clr_a, for channel B.
- ack_a  out  1  one-cycle pulse: channel A update accepted.
- ack_b  out  1  one-cycle pulse: channel B update accepted.
- bin_out  out  7  value to the decoder, always 0..99.
- sel  out  1  channel shown: 0 = A, 1 = B.
- blank  out  1  1 = no channel holds data; display must be blanked.
- ovf_a  out  1  last accepted val_a was >99.
- ovf_b  out  1  last accepted val_b was >99.

Behaviour:
- Reset (async assert, sync release): state IDLE, both channel registers 0, both has_data flags 0, dwell counter 0. Outputs: bin_out=0, sel=0, blank=1, ack_a=ack_b=0, ovf_a=ovf_b=0.
- Update path: upd_x=1 at edge n causes the following at edge n+1.
  - reg_x <= (val_x>99) ? 99 : val_x.
  - ovf_x <= (val_x>99).
  - has_data_x <= 1.
  - ack_x is high during cycle n+1 only.
  - Latency from upd to ack is 1 cycle. A new upd is accepted every cycle.
- Clear path: clr_x=1 sets has_data_x <= 0 and ovf_x <= 0; reg_x keeps its value. If upd_x and clr_x are both high in the same cycle, clr wins and ack_x stays 0.
- Output decode is combinational from registered state only:
  - bin_out = reg of the channel shown; 0 in IDLE.
  - sel = 1 in SHOW_B, else 0.
  - blank = 1 only in IDLE.
- State machine, states IDLE, SHOW_A, SHOW_B. Next-state decisions use the has_data values after this edge's updates and clears.
  - IDLE -> SHOW_A if A has data, else -> SHOW_B if B has data. If both arrive in the same cycle, A has priority.
  - SHOW_A:
    - If A loses data: go to SHOW_B if B has data, else go to IDLE. This happens on the same edge as the clear.
    - Else if cnt==DWELL-1 and B has data: go to SHOW_B.
    - Else stay in SHOW_A.
  - SHOW_B: symmetric to SHOW_A.
- Dwell counter:
  - Counts 0..DWELL-1 while in SHOW_A or SHOW_B.
  - Wraps to 0 at DWELL-1 even when no switch occurs; the channel stays shown.
  - Resets to 0 on every state change and while in IDLE.
  - An update to the channel currently shown does not restart the counter; bin_out shows the new value from cycle n+1.
- Simultaneous events:
  - Clearing the shown channel while the dwell counter expires: the clear decides the next state.
  - Clearing both channels in the same cycle: go to IDLE.
- Reset asserted mid-dwell or mid-update: all state is discarded immediately, with no pending ack.

Test Plan:
1. Reset, then idle 10 cycles -> blank=1, bin_out=0, sel=0, no acks.
2. From IDLE, upd_a with val_a=42 -> next cycle ack_a=1, state SHOW_A, bin_out=42, blank=0. Hold 3*DWELL cycles with DWELL=8 -> sel stays 0.
3. Start with A=42 shown. Then upd_b with val_b=7 -> sel switches to 1 exactly when the dwell counter reaches DWELL-1 (DWELL=8). It then alternates every 8 cycles: bin_out 42, 7, 42, ...
4. upd_a with val_a=120 -> bin_out=99, ovf_a=1. Then upd_a with val_a=5 -> bin_out=5, ovf_a=0.
5. Both channels active, A shown at cnt=3 -> clr_a -> next edge sel=1, bin_out=B value, cnt=0. Then clr_b -> blank=1, bin_out=0.
6. upd_a and clr_a asserted in the same cycle -> no ack_a, has_data_a=0. Separately, upd_a and upd_b in the same cycle from IDLE -> both acks, SHOW_A first. Assert rst_n=0 mid-dwell -> outputs return to reset values immediately, without waiting for clk.
